// File: rtl/datapath_if.sv
// Memory-side bus of the datapath: address/write data/request/write-enable
// travel out to the memory, read data and acknowledge come back.
interface datapath_if;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       mem_ack;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_req,
        output mem_we,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_req,
        input  mem_we,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/datapath.sv
// 8-bit accumulator datapath: register file on a single internal bus, ALU with
// flag generation, and a request/acknowledge memory sequencer.
// Optional build macro DATAPATH_MEM_TIMEOUT_EN: aborts a memory transaction
// after 255 cycles without acknowledge and sets the sticky flag FR[7].
module datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] C,
    input  logic [7:0]  fn,
    output logic [7:0]  OPCODE,
    output logic [7:0]  Flag,
    output logic        ready,
    datapath_if.master  mem
);
    typedef enum logic [1:0] {IDLE, RD, WR} mem_state_t;

    mem_state_t state_reg;
    logic [7:0] pc_reg, mar_reg, mdr_reg, ir_reg, acc_reg, b_reg, fr_reg;
    logic       ready_reg, req_reg, we_reg;

    logic [7:0] bus;
    logic [7:0] alu_y;
    logic [8:0] alu_sum;
    logic       alu_c, alu_v;
    logic [3:0] alu_flags;
    logic       idle, busy, rd_done, timeout_hit;

    // Upper fn nibble and C[15] are reserved and deliberately unused.
    logic unused_bits;
    assign unused_bits = ^{fn[7:4], C[15]};

    assign idle    = (state_reg == IDLE);
    assign busy    = (state_reg == RD) || (state_reg == WR);
    assign rd_done = (state_reg == RD) && mem.mem_ack;

    assign OPCODE        = ir_reg;
    assign Flag          = fr_reg;
    assign ready         = ready_reg;
    assign mem.mem_addr  = mar_reg;
    assign mem.mem_wdata = mdr_reg;
    assign mem.mem_req   = req_reg;
    assign mem.mem_we    = we_reg;

`ifdef DATAPATH_MEM_TIMEOUT_EN
    logic [7:0] wait_cnt_reg;

    // Timeout fires on the edge that ends the 255th waiting cycle.
    assign timeout_hit = busy && !mem.mem_ack && (wait_cnt_reg == 8'd254);

    // Count edges spent waiting for acknowledge; cleared whenever idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wait_cnt_reg <= 8'd0;
        else if (busy)
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
        else
            wait_cnt_reg <= 8'd0;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Internal bus source select.
    always_comb begin
        bus = 8'h00;
        case (C[3:0])
            4'd1:    bus = pc_reg;
            4'd2:    bus = mdr_reg;
            4'd3:    bus = acc_reg;
            4'd4:    bus = b_reg;
            4'd5:    bus = alu_y;
            default: bus = 8'h00;
        endcase
    end

    // ALU on ACC and B, with carry (not-borrow for subtract) and overflow.
    always_comb begin
        alu_y   = acc_reg;
        alu_sum = 9'd0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (fn[3:0])
            4'd1: begin
                alu_sum = {1'b0, acc_reg} + {1'b0, b_reg};
                alu_y   = alu_sum[7:0];
                alu_c   = alu_sum[8];
                alu_v   = (acc_reg[7] == b_reg[7]) && (alu_y[7] != acc_reg[7]);
            end
            4'd2: begin
                alu_sum = {1'b0, acc_reg} - {1'b0, b_reg};
                alu_y   = alu_sum[7:0];
                alu_c   = ~alu_sum[8];
                alu_v   = (acc_reg[7] != b_reg[7]) && (alu_y[7] != acc_reg[7]);
            end
            4'd3: alu_y = acc_reg & b_reg;
            4'd4: alu_y = acc_reg | b_reg;
            4'd5: alu_y = acc_reg ^ b_reg;
            4'd6: alu_y = ~acc_reg;
            4'd7: begin
                alu_y = {acc_reg[6:0], 1'b0};
                alu_c = acc_reg[7];
            end
            4'd8: begin
                alu_y = {1'b0, acc_reg[7:1]};
                alu_c = acc_reg[0];
            end
            4'd9: begin
                alu_sum = {1'b0, acc_reg} + {1'b0, b_reg} + {8'd0, fr_reg[1]};
                alu_y   = alu_sum[7:0];
                alu_c   = alu_sum[8];
                alu_v   = (acc_reg[7] == b_reg[7]) && (alu_y[7] != acc_reg[7]);
            end
            default: alu_y = acc_reg;
        endcase
        alu_flags = {alu_v, alu_y[7], alu_c, (alu_y == 8'h00)};
    end

    // Register transfers; control word honoured only while no transaction is pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg  <= 8'h00;
            mar_reg <= 8'h00;
            mdr_reg <= 8'h00;
            ir_reg  <= 8'h00;
            acc_reg <= 8'h00;
            b_reg   <= 8'h00;
            fr_reg  <= 8'h00;
        end else begin
            if (idle) begin
                if (C[4])
                    pc_reg <= bus;
                else if (C[5])
                    pc_reg <= pc_reg + 8'd1;
                if (C[6])  mar_reg <= bus;
                if (C[7])  mdr_reg <= bus;
                if (C[8])  ir_reg  <= bus;
                if (C[9])  acc_reg <= bus;
                if (C[10]) b_reg   <= bus;
                if (C[14])
                    fr_reg <= 8'h00;
                else if (C[13])
                    fr_reg[3:0] <= alu_flags;
            end else if (rd_done) begin
                mdr_reg <= mem.mem_rdata;
            end
            if (timeout_hit)
                fr_reg[7] <= 1'b1;
        end
    end

    // Memory sequencer with registered handshake outputs; read wins over write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (C[11]) begin
                        state_reg <= RD;
                        req_reg   <= 1'b1;
                        we_reg    <= 1'b0;
                        ready_reg <= 1'b0;
                    end else if (C[12]) begin
                        state_reg <= WR;
                        req_reg   <= 1'b1;
                        we_reg    <= 1'b1;
                        ready_reg <= 1'b0;
                    end
                end
                RD, WR: begin
                    if (mem.mem_ack || timeout_hit) begin
                        state_reg <= IDLE;
                        req_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                    we_reg    <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_datapath.sv
// Testbench for datapath: directed scenarios plus randomized ALU traffic checked
// against a behavioural model of the architectural registers.
module tb_datapath;
    localparam logic [15:0] C4  = 16'h0010, C5  = 16'h0020, C6  = 16'h0040;
    localparam logic [15:0] C8  = 16'h0100, C9  = 16'h0200, C10 = 16'h0400;
    localparam logic [15:0] C11 = 16'h0800, C12 = 16'h1000, C13 = 16'h2000;
    localparam logic [15:0] C14 = 16'h4000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] C;
    logic [7:0]  fn;
    logic [7:0]  OPCODE, Flag;
    logic        ready;

    datapath_if mem_bus ();

    datapath dut (
        .clk    (clk),
        .rst    (rst),
        .C      (C),
        .fn     (fn),
        .OPCODE (OPCODE),
        .Flag   (Flag),
        .ready  (ready),
        .mem    (mem_bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural model state
    logic [7:0] m_pc, m_mar, m_mdr, m_ir, m_acc, m_b, m_fr;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_acc = 0; m_b = 0; m_fr = 0;
    endtask

    // Returns {V,N,C,Z, result} using plain integer arithmetic.
    function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input logic cin);
        int ua, ub, sa, sb, r, sr;
        logic c, v;
        logic [7:0] y;
        ua = a; ub = b;
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        c = 0; v = 0; sr = 0;
        case (op)
            4'd1: begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            4'd2: begin r = ua - ub; c = (ua >= ub); sr = sa - sb; v = (sr > 127) || (sr < -128); end
            4'd3: r = ua & ub;
            4'd4: r = ua | ub;
            4'd5: r = ua ^ ub;
            4'd6: r = 255 - ua;
            4'd7: begin r = ua * 2; c = (ua >= 128); end
            4'd8: begin r = ua / 2; c = (ua % 2) == 1; end
            4'd9: begin
                r = ua + ub + int'(cin); c = (r > 255);
                sr = sa + sb + int'(cin); v = (sr > 127) || (sr < -128);
            end
            default: r = ua;
        endcase
        y = r[7:0];
        return {v, y[7], c, (y == 8'h00), y};
    endfunction

    // One idle cycle with control word cw; model follows the transfer rules.
    task automatic apply(input logic [15:0] cw, input logic [7:0] f);
        logic [11:0] a;
        logic [7:0]  bv;
        a = alu_model(f[3:0], m_acc, m_b, m_fr[1]);
        case (cw[3:0])
            4'd1: bv = m_pc;
            4'd2: bv = m_mdr;
            4'd3: bv = m_acc;
            4'd4: bv = m_b;
            4'd5: bv = a[7:0];
            default: bv = 8'h00;
        endcase
        C = cw; fn = f;
        if (cw[4]) m_pc = bv; else if (cw[5]) m_pc = m_pc + 8'd1;
        if (cw[6])  m_mar = bv;
        if (cw[7])  m_mdr = bv;
        if (cw[8])  m_ir  = bv;
        if (cw[9])  m_acc = bv;
        if (cw[10]) m_b   = bv;
        if (cw[14]) m_fr = 8'h00; else if (cw[13]) m_fr[3:0] = a[11:8];
        tick;
        C = 16'h0; fn = 8'h0;
    endtask

    // Issue a transaction, acknowledge it in waiting cycle ack_after, and drive
    // random control words while busy. ok=0 if handshake/hold behaviour deviated.
    task automatic mem_txn(input logic [15:0] cw, input int ack_after, input logic [7:0] rdata,
                           output int busy_cycles, output logic ok);
        logic exp_we;
        exp_we = cw[11] ? 1'b0 : 1'b1;
        ok = 1'b1;
        busy_cycles = 0;
        C = cw; fn = 8'h0;
        tick;
        for (int k = 1; k <= ack_after; k++) begin
            if (ready !== 1'b0) begin
                if (k == 1) ok = 1'b0;
            end else begin
                busy_cycles++;
            end
            if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== exp_we ||
                mem_bus.mem_addr !== m_mar || mem_bus.mem_wdata !== m_mdr ||
                OPCODE !== m_ir || Flag !== m_fr)
                ok = 1'b0;
            C  = 16'($urandom);
            fn = 8'($urandom);
            if (k == ack_after) begin
                mem_bus.mem_ack   = 1'b1;
                mem_bus.mem_rdata = rdata;
            end else begin
                mem_bus.mem_rdata = 8'($urandom);
            end
            tick;
            mem_bus.mem_ack = 1'b0;
        end
        C = 16'h0; fn = 8'h0;
        if (!exp_we) m_mdr = rdata;
        $display("[TB] txn %s addr=%02h data=%02h busy=%0d", exp_we ? "WR" : "RD",
                 m_mar, exp_we ? m_mdr : rdata, busy_cycles);
    endtask

    task automatic load_mdr(input logic [7:0] v);
        int bc; logic ok;
        mem_txn(C11, 2, v, bc, ok);
    endtask

    task automatic test_reset;
        rst = 1'b0; C = 0; fn = 0;
        mem_bus.mem_ack = 0; mem_bus.mem_rdata = 0;
        model_reset();
        tick; tick;
        n_tests++;
        if (ready !== 1'b1 || mem_bus.mem_req !== 1'b0 || mem_bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake ready=%b req=%b we=%b want 1 0 0", ready, mem_bus.mem_req, mem_bus.mem_we);
        end
        n_tests++;
        if ({OPCODE, Flag, mem_bus.mem_addr, mem_bus.mem_wdata} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs ir=%02h fr=%02h mar=%02h mdr=%02h want 0", OPCODE, Flag, mem_bus.mem_addr, mem_bus.mem_wdata);
        end
        rst = 1'b1;
        tick;
        $display("[TB] test_reset done");
    endtask

    task automatic test_fetch;
        int bc; logic ok;
        load_mdr(8'h10);
        apply(16'h0002 | C4, 0);
        apply(16'h0001 | C6 | C5, 0);
        n_tests++;
        if (mem_bus.mem_addr !== 8'h10) begin
            n_fail++; $display("FAIL fetch_mar got=%02h want=10", mem_bus.mem_addr);
        end
        mem_txn(C11, 3, 8'hA5, bc, ok);
        n_tests++;
        if (bc != 3 || ok !== 1'b1) begin
            n_fail++; $display("FAIL fetch_busy got=%0d ok=%b want=3 ok=1", bc, ok);
        end
        apply(16'h0002 | C8, 0);
        n_tests++;
        if (OPCODE !== 8'hA5) begin
            n_fail++; $display("FAIL fetch_opcode got=%02h want=a5", OPCODE);
        end
        apply(16'h0001 | C6, 0);
        n_tests++;
        if (mem_bus.mem_addr !== 8'h11) begin
            n_fail++; $display("FAIL fetch_pc got=%02h want=11", mem_bus.mem_addr);
        end
        $display("[TB] test_fetch done");
    endtask

    task automatic test_alu;
        load_mdr(8'h7F); apply(16'h0002 | C9, 0);
        load_mdr(8'h01); apply(16'h0002 | C10, 0);
        apply(16'h0005 | C9 | C13, 8'h01);
        n_tests++;
        if (Flag !== 8'h0C) begin
            n_fail++; $display("FAIL alu_add_flags got=%02h want=0c", Flag);
        end
        apply(16'h0003 | C6, 0);
        n_tests++;
        if (mem_bus.mem_addr !== 8'h80) begin
            n_fail++; $display("FAIL alu_add_acc got=%02h want=80", mem_bus.mem_addr);
        end
        load_mdr(8'h80); apply(16'h0002 | C10, 0);
        apply(16'h0005 | C9 | C13, 8'hF2);
        n_tests++;
        if (Flag !== 8'h03) begin
            n_fail++; $display("FAIL alu_sub_flags got=%02h want=03", Flag);
        end
        apply(16'h0003 | C6, 0);
        n_tests++;
        if (mem_bus.mem_addr !== 8'h00) begin
            n_fail++; $display("FAIL alu_sub_acc got=%02h want=00", mem_bus.mem_addr);
        end
        $display("[TB] test_alu done");
    endtask

    task automatic test_write;
        int bc; logic ok;
        load_mdr(8'h20); apply(16'h0002 | C6, 0);
        load_mdr(8'h5A);
        // Read and write requested together: read only, we must stay low.
        mem_txn(C11 | C12, 2, 8'h5A, bc, ok);
        n_tests++;
        if (ok !== 1'b1 || bc != 2) begin
            n_fail++; $display("FAIL write_both_is_read ok=%b busy=%0d want ok=1 busy=2", ok, bc);
        end
        mem_txn(C12, 4, 8'hEE, bc, ok);
        n_tests++;
        if (ok !== 1'b1 || bc != 4) begin
            n_fail++; $display("FAIL write_txn ok=%b busy=%0d want ok=1 busy=4", ok, bc);
        end
        n_tests++;
        if (mem_bus.mem_wdata !== 8'h5A || ready !== 1'b1 || mem_bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL write_after mdr=%02h ready=%b req=%b want 5a 1 0", mem_bus.mem_wdata, ready, mem_bus.mem_req);
        end
        $display("[TB] test_write done");
    endtask

    task automatic test_pc_wrap;
        load_mdr(8'hFF); apply(16'h0002 | C4, 0);
        apply(C5, 0);
        apply(16'h0001 | C6, 0);
        n_tests++;
        if (mem_bus.mem_addr !== 8'h00) begin
            n_fail++; $display("FAIL pc_wrap got=%02h want=00", mem_bus.mem_addr);
        end
        load_mdr(8'h33); apply(16'h0002 | C9, 0);
        apply(16'h0003 | C4 | C5, 0);
        apply(16'h0001 | C6, 0);
        n_tests++;
        if (mem_bus.mem_addr !== 8'h33) begin
            n_fail++; $display("FAIL pc_priority got=%02h want=33", mem_bus.mem_addr);
        end
        $display("[TB] test_pc_wrap done");
    endtask

    task automatic test_reset_mid_read;
        load_mdr(8'h77);
        C = C11; tick; C = 16'h0;
        tick; tick;
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (mem_bus.mem_req !== 1'b0 || ready !== 1'b1 || mem_bus.mem_wdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_mid_read req=%b ready=%b mdr=%02h want 0 1 00", mem_bus.mem_req, ready, mem_bus.mem_wdata);
        end
        model_reset();
        tick;
        rst = 1'b1;
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 8'hC3;
        tick; tick;
        mem_bus.mem_ack = 1'b0;
        n_tests++;
        if (mem_bus.mem_wdata !== 8'h00 || mem_bus.mem_req !== 1'b0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL late_ack_ignored mdr=%02h req=%b ready=%b want 00 0 1", mem_bus.mem_wdata, mem_bus.mem_req, ready);
        end
        $display("[TB] test_reset_mid_read done");
    endtask

    task automatic test_random_alu;
        logic [15:0] cw;
        for (int i = 0; i < 40; i++) begin
            load_mdr(8'($urandom)); apply(16'h0002 | C9, 0);
            load_mdr(8'($urandom)); apply(16'h0002 | C10, 0);
            cw = 16'h0005 | C9 | C13;
            if ($urandom_range(7) == 0) cw = cw | C14;
            apply(cw, 8'($urandom));
            n_tests++;
            if (Flag !== m_fr) begin
                n_fail++; $display("FAIL rand_flags[%0d] got=%02h want=%02h", i, Flag, m_fr);
            end
            apply(16'h0003 | C6, 0);
            n_tests++;
            if (mem_bus.mem_addr !== m_acc) begin
                n_fail++; $display("FAIL rand_acc[%0d] got=%02h want=%02h", i, mem_bus.mem_addr, m_acc);
            end
        end
        $display("[TB] test_random_alu done");
    endtask

`ifdef DATAPATH_MEM_TIMEOUT_EN
    task automatic test_timeout;
        int cnt;
        load_mdr(8'h4E);
        C = C11; tick; C = 16'h0;
        cnt = 0;
        while (mem_bus.mem_req === 1'b1 && cnt < 400) begin
            cnt++;
            tick;
        end
        n_tests++;
        if (cnt != 255) begin
            n_fail++; $display("FAIL timeout_cycles got=%0d want=255", cnt);
        end
        n_tests++;
        if (Flag[7] !== 1'b1 || mem_bus.mem_wdata !== 8'h4E || ready !== 1'b1) begin
            n_fail++; $display("FAIL timeout_state flag=%02h mdr=%02h ready=%b want 1xxxxxxx 4e 1", Flag, mem_bus.mem_wdata, ready);
        end
        m_fr[7] = 1'b1;
        apply(C14, 0);
        n_tests++;
        if (Flag !== 8'h00) begin
            n_fail++; $display("FAIL timeout_clear got=%02h want=00", Flag);
        end
        $display("[TB] test_timeout done");
    endtask
`endif

    initial begin
        rst = 1'b0; C = 16'h0; fn = 8'h0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 8'h0;
        test_reset();
        test_fetch();
        test_alu();
        test_write();
        test_pc_wrap();
        test_reset_mid_read();
        test_random_alu();
`ifdef DATAPATH_MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have port: clk  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: C  in  16  register-transfer control word from the control unit.
REQ-004 SHALL have port: fn  in  8  ALU function select from the control unit.
REQ-005 SHALL have port: OPCODE  out  8  current IR contents, returned to the control unit.
REQ-006 SHALL have port: Flag  out  8  flag register {E,0,0,0,V,N,C,Z} (bit7..bit0).
REQ-007 SHALL have port: ready  out  1  high when no memory transaction is pending.
REQ-008 SHALL have ports: mem_addr out 8, mem_wdata out 8, mem_req out 1, mem_we out 1, mem_rdata in 8, mem_ack in 1.

Function
REQ-009 SHALL hold 8-bit registers PC, MAR, MDR, IR, ACC, B, FR, and drive OPCODE=IR, Flag=FR, mem_addr=MAR, mem_wdata=MDR.
REQ-010 SHALL drive the internal bus from C[3:0]: 0 none (0x00), 1 PC, 2 MDR, 3 ACC, 4 B, 5 ALU result, 6-15 0x00.
REQ-011 SHALL apply loads on the edge: C[4] PC<=bus, C[5] PC<=PC+1 mod 256, C[6] MAR<=bus, C[7] MDR<=bus, C[8] IR<=bus, C[9] ACC<=bus, C[10] B<=bus; multiple loads in one cycle all take effect.
REQ-012 SHALL give C[4] priority over C[5] when both asserted.
REQ-013 SHALL compute the ALU combinationally on A=ACC, B=B per fn[3:0]: 0 pass A, 1 A+B, 2 A-B, 3 AND, 4 OR, 5 XOR, 6 NOT A, 7 A<<1, 8 A>>1 (logical), 9 A+B+FR.C, 10-15 pass A; fn[7:4] ignored.
REQ-014 SHALL compute flags: Z = result==0; N = result[7]; C = carry-out for 1/9, NOT borrow for 2, shifted-out bit for 7/8, 0 otherwise; V = signed overflow for 1/2/9, 0 otherwise.
REQ-015 SHALL update FR[3:0] on C[13]; C[14] clears FR to 0x00 and wins over C[13].
REQ-016 SHALL run a memory FSM IDLE -> RD or WR -> IDLE; C[11] in IDLE starts read, C[12] starts write; both asserted -> read only.
REQ-017 SHALL, in RD/WR, assert mem_req=1 (mem_we=1 for WR) and ready=0 from the cycle after the start until the edge mem_ack is sampled high; minimum transaction latency 2 cycles.
REQ-018 SHALL, on read ack, load MDR<=mem_rdata on that same edge and return to IDLE; on write ack, return to IDLE.
REQ-019 SHALL ignore all of C (no register, flag or memory action) while ready=0; mem_ack in IDLE ignored.
REQ-020 SHALL hold MAR and MDR constant throughout a transaction.
REQ-021 SHALL keep FR[6:4]=0; FR[7] per REQ-027.

Reset
REQ-022 SHALL, while rst=0, immediately force all registers to 0x00, FSM to IDLE, mem_req=0, mem_we=0, ready=1, regardless of clock.
REQ-023 SHALL abort an in-flight transaction on reset with no MDR update; mem_ack arriving after reset release is ignored.
REQ-024 SHALL resume normal operation on the first rising clk edge after rst returns to 1.

Configuration
REQ-025 SHALL compile a memory timeout when macro DATAPATH_MEM_TIMEOUT_EN is defined.
REQ-026 SHALL, with DATAPATH_MEM_TIMEOUT_EN, count cycles in RD/WR with an 8-bit counter; at 255 cycles without mem_ack, abort to IDLE, drop mem_req, leave MDR unchanged, set FR[7]=1.
REQ-027 SHALL keep FR[7] sticky until C[14] or reset; without the macro the FSM waits indefinitely and FR[7] is constant 0.

Verification
REQ-028 SHALL test fetch: PC=0x10, C[3:0]=1+C[6]+C[5], then C[11], mem_ack after 3 cycles with rdata=0xA5, then C[3:0]=2+C[8] -> MAR=0x10, PC=0x11, OPCODE=0xA5, ready low 3 cycles.
REQ-029 SHALL test ALU: ACC=0x7F, B=0x01, fn=1, C[3:0]=5+C[9]+C[13] -> ACC=0x80, Flag=0x0C (V,N); then fn=2 with B=0x80 -> ACC=0x00, Flag Z=1, C=1.
REQ-030 SHALL test write: MAR=0x20, MDR=0x5A, C[11]+C[12] together -> only read issued (mem_we=0); next C[12] -> mem_we=1, mem_wdata=0x5A until ack.
REQ-031 SHALL test reset mid-read: rst=0 two cycles after C[11] -> mem_req drops without clock, MDR=0x00, late ack ignored.
REQ-032 SHALL test PC wrap and priority: PC=0xFF, C[5] -> 0x00; C[4]+C[5] with bus=ACC=0x33 -> PC=0x33; C sent while ready=0 has no effect.
REQ-033 SHALL test, with DATAPATH_MEM_TIMEOUT_EN, no ack after C[11] -> mem_req drops after 255 cycles, Flag[7]=1, cleared by C[14].
